// File: rtl/pmod_ssd_capture.sv
// rtl/pmod_ssd_capture.sv - PmodSSD pin-bus capture: sync, stability filter, 7-seg decode, digit pairing
module pmod_ssd_capture #(
    parameter int unsigned par_stable_cycles  = 16,
    parameter int unsigned par_timeout_cycles = 400000
) (
    input  logic       i_clk_20mhz,
    input  logic       i_rst_20mhz,
    input  logic [7:0] i_ssd_pmod,
    output logic [7:0] o_value,
    output logic       o_valid,
    output logic       o_update,
    output logic       o_err
);
    localparam int unsigned tmo_w = $clog2(par_timeout_cycles + 1);
    localparam logic [15:0] stab_max = 16'(par_stable_cycles - 1);
    localparam logic [tmo_w-1:0] tmo_max = tmo_w'(par_timeout_cycles);

    typedef enum logic [0:0] {ST_WAIT0, ST_WAIT1} state_t;

    logic [7:0]       sync1, sync2, w_prev;
    logic [15:0]      stab_cnt;
    logic             captured;
    logic [tmo_w-1:0] tmo_cnt;
    state_t           state_q, state_d;
    logic [3:0]       digit0_q, digit0_d;
    logic [7:0]       value_d;
    logic             valid_d, update_d, err_d;
    logic             accept, tmo_expire;
    logic [3:0]       dec_nib;
    logic             dec_ok, dec_blank;

    // The accepted word is w_prev: it has matched for par_stable_cycles samples.
    assign accept     = (stab_cnt == stab_max) && !captured;
    assign tmo_expire = !accept && (tmo_cnt == tmo_max - 1'b1);

    always_comb begin
        dec_nib   = 4'h0;
        dec_ok    = 1'b1;
        dec_blank = 1'b0;
        case (w_prev[6:0])
            7'b0111111: dec_nib = 4'h0;
            7'b0000110: dec_nib = 4'h1;
            7'b1011011: dec_nib = 4'h2;
            7'b1001111: dec_nib = 4'h3;
            7'b1100110: dec_nib = 4'h4;
            7'b1101101: dec_nib = 4'h5;
            7'b1111101: dec_nib = 4'h6;
            7'b0000111: dec_nib = 4'h7;
            7'b1111111: dec_nib = 4'h8;
            7'b1100111: dec_nib = 4'h9;
            7'b1110111: dec_nib = 4'hA;
            7'b1111100: dec_nib = 4'hB;
            7'b0111001: dec_nib = 4'hC;
            7'b1011110: dec_nib = 4'hD;
            7'b1111001: dec_nib = 4'hE;
            7'b1110001: dec_nib = 4'hF;
            7'b0000000: begin dec_ok = 1'b0; dec_blank = 1'b1; end
            default:    dec_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        digit0_d = digit0_q;
        value_d  = o_value;
        valid_d  = o_valid;
        update_d = 1'b0;
        err_d    = o_err;
        if (accept) begin
            if (!dec_ok && !dec_blank)
                err_d = 1'b1;
            case (state_q)
                ST_WAIT0: begin
                    if (dec_ok && !w_prev[7]) begin
                        digit0_d = dec_nib;
                        state_d  = ST_WAIT1;
                    end
                end
                ST_WAIT1: begin
                    if (!dec_ok) begin
                        state_d = ST_WAIT0;
                    end else if (w_prev[7]) begin
                        value_d  = {dec_nib, digit0_q};
                        valid_d  = 1'b1;
                        update_d = 1'b1;
                        state_d  = ST_WAIT0;
                    end else begin
                        digit0_d = dec_nib;
                    end
                end
                default: state_d = ST_WAIT0;
            endcase
        end else if (tmo_expire) begin
            valid_d = 1'b0;
            state_d = ST_WAIT0;
        end
    end

    always_ff @(posedge i_clk_20mhz) begin
        if (!i_rst_20mhz) begin
            sync1    <= '0;
            sync2    <= '0;
            w_prev   <= '0;
            stab_cnt <= '0;
            captured <= 1'b0;
            tmo_cnt  <= '0;
            state_q  <= ST_WAIT0;
            digit0_q <= '0;
            o_value  <= '0;
            o_valid  <= 1'b0;
            o_update <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            sync1  <= i_ssd_pmod;
            sync2  <= sync1;
            w_prev <= sync2;
            if (sync2 != w_prev) begin
                stab_cnt <= '0;
                captured <= 1'b0;
            end else begin
                if (stab_cnt != stab_max)
                    stab_cnt <= stab_cnt + 16'd1;
                if (accept)
                    captured <= 1'b1;
            end
            if (accept)
                tmo_cnt <= '0;
            else if (tmo_cnt != tmo_max)
                tmo_cnt <= tmo_cnt + 1'b1;
            state_q  <= state_d;
            digit0_q <= digit0_d;
            o_value  <= value_d;
            o_valid  <= valid_d;
            o_update <= update_d;
            o_err    <= err_d;
        end
    end
endmodule
